// File: rtl/addr_sequencer.sv
// Effective-address sequencer: fetches operand and pointer bytes for the
// multi-byte addressing modes and returns a full effective address plus page-cross flag.
module addr_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter bit PAGE_FIX   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                mode,
  input  logic                      force_fix,
  input  logic [DATA_WIDTH-1:0]     index,
  input  logic [2*DATA_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0]     data_read,
  output logic [2*DATA_WIDTH-1:0]   address,
  output logic                      pc_increment,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   ea,
  output logic                      page_cross
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP_LO  = 3'd1,
    S_OP_HI  = 3'd2,
    S_PTR_LO = 3'd3,
    S_PTR_HI = 3'd4,
    S_FIX    = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [DATA_WIDTH-1:0] ZERO_B = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_B  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic [2:0]                mode_q, mode_d;
  logic [DATA_WIDTH-1:0]     index_q, index_d;
  logic                      force_q, force_d;
  logic [DATA_WIDTH-1:0]     lo_q, lo_d;
  logic [DATA_WIDTH-1:0]     hi_q, hi_d;
  logic [2*DATA_WIDTH-1:0]   ptr_q, ptr_d;
  logic                      carry_q, carry_d;
  logic [2*DATA_WIDTH-1:0]   ea_q, ea_d;
  logic                      page_cross_q, page_cross_d;
  logic                      done_q, done_d;
  logic [DATA_WIDTH:0]       sum_w;
  logic                      need_fix_w;

  // Low byte plus index; the carry decides the page fix for modes 3 and 5.
  assign sum_w      = {1'b0, lo_q} + {1'b0, index_q};
  assign need_fix_w = sum_w[DATA_WIDTH] | force_q | (PAGE_FIX == 1'b0);

  assign done       = done_q;
  assign ea         = ea_q;
  assign page_cross = page_cross_q;

  // Next-state, datapath latch updates and bus-side outputs.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    index_d      = index_q;
    force_d      = force_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    ptr_d        = ptr_q;
    carry_d      = carry_q;
    ea_d         = ea_q;
    page_cross_d = page_cross_q;
    done_d       = 1'b0;
    address      = pc;
    pc_increment = 1'b0;
    busy         = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = mode;
          index_d = index;
          force_d = force_fix;
          if (mode == 3'd7) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            ea_d         = {2*DATA_WIDTH{1'b0}};
            page_cross_d = 1'b0;
          end else begin
            state_d = S_OP_LO;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OP_LO: begin
        busy         = 1'b1;
        pc_increment = 1'b1;
        case (mode_q)
          3'd0: begin
            ea_d         = {ZERO_B, data_read};
            page_cross_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_DONE;
          end
          3'd1: begin
            ea_d         = {ZERO_B, data_read + index_q};
            page_cross_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_DONE;
          end
          3'd2, 3'd3, 3'd6: begin
            lo_d    = data_read;
            state_d = S_OP_HI;
          end
          3'd4: begin
            ptr_d   = {ZERO_B, data_read + index_q};
            state_d = S_PTR_LO;
          end
          3'd5: begin
            ptr_d   = {ZERO_B, data_read};
            state_d = S_PTR_LO;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_OP_HI: begin
        busy         = 1'b1;
        pc_increment = 1'b1;
        case (mode_q)
          3'd2: begin
            ea_d         = {data_read, lo_q};
            page_cross_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_DONE;
          end
          3'd3: begin
            hi_d    = data_read;
            lo_d    = sum_w[DATA_WIDTH-1:0];
            carry_d = sum_w[DATA_WIDTH];
            if (need_fix_w) begin
              state_d = S_FIX;
            end else begin
              ea_d         = {data_read, sum_w[DATA_WIDTH-1:0]};
              page_cross_d = sum_w[DATA_WIDTH];
              done_d       = 1'b1;
              state_d      = S_DONE;
            end
          end
          3'd6: begin
            ptr_d   = {data_read, lo_q};
            state_d = S_PTR_LO;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_PTR_LO: begin
        busy    = 1'b1;
        address = ptr_q;
        lo_d    = data_read;
        state_d = S_PTR_HI;
      end
      S_PTR_HI: begin
        // Pointer high byte always wraps within the pointer's page.
        busy    = 1'b1;
        address = {ptr_q[2*DATA_WIDTH-1:DATA_WIDTH], ptr_q[DATA_WIDTH-1:0] + ONE_B};
        if (mode_q == 3'd5) begin
          hi_d    = data_read;
          lo_d    = sum_w[DATA_WIDTH-1:0];
          carry_d = sum_w[DATA_WIDTH];
          if (need_fix_w) begin
            state_d = S_FIX;
          end else begin
            ea_d         = {data_read, sum_w[DATA_WIDTH-1:0]};
            page_cross_d = sum_w[DATA_WIDTH];
            done_d       = 1'b1;
            state_d      = S_DONE;
          end
        end else begin
          ea_d         = {data_read, lo_q};
          page_cross_d = 1'b0;
          done_d       = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_FIX: begin
        busy         = 1'b1;
        address      = {hi_q, lo_q};
        ea_d         = {hi_q + {{(DATA_WIDTH-1){1'b0}}, carry_q}, lo_q};
        page_cross_d = carry_q;
        done_d       = 1'b1;
        state_d      = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 3'd0;
      index_q      <= {DATA_WIDTH{1'b0}};
      force_q      <= 1'b0;
      lo_q         <= {DATA_WIDTH{1'b0}};
      hi_q         <= {DATA_WIDTH{1'b0}};
      ptr_q        <= {2*DATA_WIDTH{1'b0}};
      carry_q      <= 1'b0;
      ea_q         <= {2*DATA_WIDTH{1'b0}};
      page_cross_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      index_q      <= index_d;
      force_q      <= force_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      ptr_q        <= ptr_d;
      carry_q      <= carry_d;
      ea_q         <= ea_d;
      page_cross_q <= page_cross_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed bench for addr_sequencer: memory model, PC model advancing on pc_increment,
// one task per scenario with inline expected-value checks.
module tb_addr_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, force_fix;
  logic [2:0]  mode;
  logic [7:0]  index, data_read;
  logic [15:0] pc, address, ea;
  logic        pc_increment, busy, done, page_cross;
  logic [7:0]  mem [0:65535];

  logic [15:0] obs_addr;
  logic        obs_busy, obs_inc, obs_done;
  logic [15:0] tr [0:15];
  int nbusy, ninc, ndone, done_k, last_busy_k;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  assign data_read = mem[address];

  addr_sequencer #(.DATA_WIDTH(8), .PAGE_FIX(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .force_fix(force_fix),
    .index(index), .pc(pc), .data_read(data_read), .address(address),
    .pc_increment(pc_increment), .busy(busy), .done(done), .ea(ea), .page_cross(page_cross)
  );

  task automatic step();
    @(negedge clk);
    obs_addr = address; obs_busy = busy; obs_inc = pc_increment; obs_done = done;
    @(posedge clk);
    #1;
    if (obs_inc === 1'b1) pc = pc + 16'd1;
  endtask

  // Pulse start, then observe a fixed window; optionally re-pulse start at window step pulse_k.
  task automatic run_op(input logic [2:0] m, input logic [7:0] idx, input logic f, input int pulse_k);
    mode = m; index = idx; force_fix = f; start = 1'b1;
    step();
    start = 1'b0; nbusy = 0; ninc = 0; ndone = 0; done_k = -1; last_busy_k = -1;
    for (int k = 0; k < 8; k++) begin
      if (k == pulse_k) begin start = 1'b1; index = 8'hFF; end
      step();
      start = 1'b0;
      if (obs_busy === 1'b1) begin tr[nbusy] = obs_addr; nbusy++; last_busy_k = k; end
      if (obs_inc === 1'b1) ninc++;
      if (obs_done === 1'b1) begin ndone++; if (done_k < 0) done_k = k; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mode = 3'd0; force_fix = 1'b0; index = 8'h00; pc = 16'h0200;
    step(); step();
    rst = 1'b1;
    step();
    n_checks++; if (obs_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", obs_busy); else n_pass++;
    n_checks++; if (obs_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", obs_done); else n_pass++;
    n_checks++; if (obs_inc !== 1'b0) $display("FAIL reset_pcinc: got %b expected 0", obs_inc); else n_pass++;
    n_checks++; if (ea !== 16'h0000) $display("FAIL reset_ea: got %h expected 0000", ea); else n_pass++;
    n_checks++; if (page_cross !== 1'b0) $display("FAIL reset_pc_cross: got %b expected 0", page_cross); else n_pass++;
    n_checks++; if (obs_addr !== 16'h0200) $display("FAIL reset_addr: got %h expected 0200", obs_addr); else n_pass++;
  endtask

  task automatic test_mode0();
    pc = 16'h0200; mem[16'h0200] = 8'h42;
    run_op(3'd0, 8'h00, 1'b0, -1);
    n_checks++; if (ndone !== 1) $display("FAIL m0_done_count: got %0d expected 1", ndone); else n_pass++;
    n_checks++; if (ninc !== 1) $display("FAIL m0_pcinc: got %0d expected 1", ninc); else n_pass++;
    n_checks++; if (done_k !== last_busy_k + 1) $display("FAIL m0_done_timing: got %0d expected %0d", done_k, last_busy_k + 1); else n_pass++;
    n_checks++; if (tr[0] !== 16'h0200) $display("FAIL m0_addr: got %h expected 0200", tr[0]); else n_pass++;
    n_checks++; if (ea !== 16'h0042) $display("FAIL m0_ea: got %h expected 0042", ea); else n_pass++;
    n_checks++; if (page_cross !== 1'b0) $display("FAIL m0_pcross: got %b expected 0", page_cross); else n_pass++;
  endtask

  task automatic test_abs_idx_carry();
    pc = 16'h0300; mem[16'h0300] = 8'hF0; mem[16'h0301] = 8'h12;
    run_op(3'd3, 8'h20, 1'b0, -1);
    n_checks++; if (nbusy !== 3) $display("FAIL m3c_busy: got %0d expected 3", nbusy); else n_pass++;
    n_checks++; if (ninc !== 2) $display("FAIL m3c_pcinc: got %0d expected 2", ninc); else n_pass++;
    n_checks++; if (tr[2] !== 16'h1210) $display("FAIL m3c_fix_addr: got %h expected 1210", tr[2]); else n_pass++;
    n_checks++; if (ndone !== 1) $display("FAIL m3c_done_count: got %0d expected 1", ndone); else n_pass++;
    n_checks++; if (ea !== 16'h1310) $display("FAIL m3c_ea: got %h expected 1310", ea); else n_pass++;
    n_checks++; if (page_cross !== 1'b1) $display("FAIL m3c_pcross: got %b expected 1", page_cross); else n_pass++;
  endtask

  task automatic test_reserved();
    run_op(3'd7, 8'h00, 1'b0, -1);
    n_checks++; if (nbusy !== 0) $display("FAIL m7_busy: got %0d expected 0", nbusy); else n_pass++;
    n_checks++; if (ndone !== 1) $display("FAIL m7_done_count: got %0d expected 1", ndone); else n_pass++;
    n_checks++; if (ea !== 16'h0000) $display("FAIL m7_ea: got %h expected 0000", ea); else n_pass++;
    n_checks++; if (page_cross !== 1'b0) $display("FAIL m7_pcross: got %b expected 0", page_cross); else n_pass++;
  endtask

  task automatic test_abs_idx_nocarry();
    pc = 16'h0300;
    run_op(3'd3, 8'h05, 1'b0, -1);
    n_checks++; if (nbusy !== 2) $display("FAIL m3n_busy: got %0d expected 2", nbusy); else n_pass++;
    n_checks++; if (ea !== 16'h12F5) $display("FAIL m3n_ea: got %h expected 12F5", ea); else n_pass++;
    n_checks++; if (page_cross !== 1'b0) $display("FAIL m3n_pcross: got %b expected 0", page_cross); else n_pass++;
  endtask

  task automatic test_zp_idx();
    pc = 16'h0380; mem[16'h0380] = 8'hF0;
    run_op(3'd1, 8'h20, 1'b0, -1);
    n_checks++; if (nbusy !== 1) $display("FAIL m1_busy: got %0d expected 1", nbusy); else n_pass++;
    n_checks++; if (ea !== 16'h0010) $display("FAIL m1_ea: got %h expected 0010", ea); else n_pass++;
  endtask

  task automatic test_zp_x_ind();
    pc = 16'h0400; mem[16'h0400] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    run_op(3'd4, 8'h01, 1'b0, -1);
    n_checks++; if (nbusy !== 3) $display("FAIL m4_busy: got %0d expected 3", nbusy); else n_pass++;
    n_checks++; if (tr[1] !== 16'h00FF) $display("FAIL m4_ptr_lo: got %h expected 00FF", tr[1]); else n_pass++;
    n_checks++; if (tr[2] !== 16'h0000) $display("FAIL m4_ptr_hi: got %h expected 0000", tr[2]); else n_pass++;
    n_checks++; if (ea !== 16'h1234) $display("FAIL m4_ea: got %h expected 1234", ea); else n_pass++;
  endtask

  task automatic test_abs_ind();
    pc = 16'h0500; mem[16'h0500] = 8'hFF; mem[16'h0501] = 8'h30;
    mem[16'h30FF] = 8'hCD; mem[16'h3000] = 8'hAB;
    run_op(3'd6, 8'h00, 1'b0, -1);
    n_checks++; if (nbusy !== 4) $display("FAIL m6_busy: got %0d expected 4", nbusy); else n_pass++;
    n_checks++; if (tr[2] !== 16'h30FF) $display("FAIL m6_ptr_lo: got %h expected 30FF", tr[2]); else n_pass++;
    n_checks++; if (tr[3] !== 16'h3000) $display("FAIL m6_ptr_hi: got %h expected 3000", tr[3]); else n_pass++;
    n_checks++; if (pc !== 16'h0502) $display("FAIL m6_pc: got %h expected 0502", pc); else n_pass++;
    n_checks++; if (ea !== 16'hABCD) $display("FAIL m6_ea: got %h expected ABCD", ea); else n_pass++;
  endtask

  task automatic test_back_to_back();
    pc = 16'h0600; mem[16'h0600] = 8'h80; mem[16'h0080] = 8'h10; mem[16'h0081] = 8'h22;
    run_op(3'd5, 8'h03, 1'b1, 1);
    n_checks++; if (nbusy !== 4) $display("FAIL m5_busy: got %0d expected 4", nbusy); else n_pass++;
    n_checks++; if (tr[3] !== 16'h2213) $display("FAIL m5_fix_addr: got %h expected 2213", tr[3]); else n_pass++;
    n_checks++; if (ndone !== 1) $display("FAIL m5_done_count: got %0d expected 1", ndone); else n_pass++;
    n_checks++; if (ea !== 16'h2213) $display("FAIL m5_ea: got %h expected 2213", ea); else n_pass++;
    n_checks++; if (page_cross !== 1'b0) $display("FAIL m5_pcross: got %b expected 0", page_cross); else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic hi_busy;
    pc = 16'h0700; mem[16'h0700] = 8'h34; mem[16'h0701] = 8'h56;
    mode = 3'd2; index = 8'h00; force_fix = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b0;
    step();
    hi_busy = obs_busy;
    rst = 1'b1;
    step();
    n_checks++; if (hi_busy !== 1'b1) $display("FAIL rmid_was_busy: got %b expected 1", hi_busy); else n_pass++;
    n_checks++; if (obs_busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", obs_busy); else n_pass++;
    n_checks++; if (obs_done !== 1'b0) $display("FAIL rmid_done: got %b expected 0", obs_done); else n_pass++;
    n_checks++; if (ea !== 16'h0000) $display("FAIL rmid_ea: got %h expected 0000", ea); else n_pass++;
    step();
    n_checks++; if (obs_done !== 1'b0) $display("FAIL rmid_late_done: got %b expected 0", obs_done); else n_pass++;
    pc = 16'h0700;
    run_op(3'd2, 8'h00, 1'b0, -1);
    n_checks++; if (nbusy !== 2) $display("FAIL m2_busy: got %0d expected 2", nbusy); else n_pass++;
    n_checks++; if (ndone !== 1) $display("FAIL m2_done_count: got %0d expected 1", ndone); else n_pass++;
    n_checks++; if (ea !== 16'h5634) $display("FAIL m2_ea: got %h expected 5634", ea); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_abs_idx_carry();
    test_reserved();
    test_abs_idx_nocarry();
    test_zp_idx();
    test_zp_x_ind();
    test_abs_ind();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
Parametrised effective-address generator that sits between the control unit and the memory address mux. It takes over operand fetch for the multi-byte addressing modes: zero page, zero page indexed, absolute, absolute indexed, (zp,X), (zp),Y and (abs). It drives the bus address, requests PC increments, and returns a full effective address plus a page-cross flag. Generalises the current PC-or-fixed address path to DATA_WIDTH-wide pages and an optional page-fix cycle.

Parameters:
DATA_WIDTH, 8, byte width; address width is fixed at 2*DATA_WIDTH and a page is 2^DATA_WIDTH bytes.
PAGE_FIX, 1, 1 = page-fix cycle inserted only on carry or force_fix; 0 = fix cycle always inserted for modes 3 and 5.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-low.
start  in  1  one-cycle request from the control unit; sampled only in IDLE/DONE.
mode  in  3  0 ZP, 1 ZP+idx, 2 ABS, 3 ABS+idx, 4 (zp,idx), 5 (zp),idx, 6 (abs), 7 reserved.
force_fix  in  1  forces the fix cycle in modes 3/5 (write/RMW ops); sampled with start.
index  in  DATA_WIDTH  X or Y value chosen upstream; sampled with start.
pc  in  2*DATA_WIDTH  current program counter.
data_read  in  DATA_WIDTH  memory read data, combinationally valid for the address presented in the same cycle.
address  out  2*DATA_WIDTH  bus address.
pc_increment  out  1  high in each operand-fetch cycle at pc.
busy  out  1  high in every bus cycle of an operation.
done  out  1  one-cycle pulse: operation complete.
ea  out  2*DATA_WIDTH  effective address, valid from done until the next accepted start.
page_cross  out  1  carry out of low-byte index add (modes 3/5); valid with ea.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; ea=0, page_cross=0, done=0, busy=0, pc_increment=0; internal byte latches cleared. Reset mid-operation aborts it with no done pulse.
- States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIX, DONE. In IDLE and DONE: address=pc, busy=0.
- start in IDLE or DONE latches mode, index and force_fix, then enters OP_LO on the next edge. start while busy is ignored. Mode 7 goes straight to DONE with ea=0 and page_cross=0.
- OP_LO / OP_HI: address=pc, pc_increment=1, and the byte is latched at the clock edge.
- Mode 0: ea={0,b}.
- Mode 1: ea={0,(b+index) mod 2^DW}. Stays in zero page; page_cross=0.
- Mode 2: ea={hi,lo}.
- Mode 3: sum=lo+index, ea={hi+carry, sum[DW-1:0]}.
  - FIX cycle when carry, or force_fix, or PAGE_FIX=0.
  - FIX drives address={hi, sum[DW-1:0]} as a dummy read; data is ignored.
- Mode 4: ptr=(b+index) mod 2^DW. PTR_LO reads {0,ptr}; PTR_HI reads {0,(ptr+1) mod 2^DW}; ea={hi,lo}.
- Mode 5: PTR_LO reads {0,b}; PTR_HI reads {0,(b+1) mod 2^DW}; index add and FIX rule as mode 3.
- Mode 6: after OP_LO/OP_HI, PTR_LO reads {ph,pl} and PTR_HI reads {ph,(pl+1) mod 2^DW}. The page wrap is intentional and hi is not incremented.
- Bus cycles (busy high): modes 0/1 = 1; mode 2 = 2; mode 3 = 2 (+1 FIX); mode 4 = 3; mode 5 = 3 (+1 FIX); mode 6 = 4.
- done is high for exactly the one cycle after the last bus cycle; ea and page_cross update at that same edge.
- Without a new start, DONE returns to IDLE on the next edge.
- page_cross reflects the true carry even when the FIX cycle is forced.

Test Plan:
- Reset then mode 0, pc=0x0200, mem[0x0200]=0x42 -> pc_increment high for 1 cycle; done the next cycle; ea=0x0042; page_cross=0.
- Mode 3, index=0x20, operand bytes F0,12:
  - Expect 2 fetches, then FIX with address=0x1210, then done; ea=0x1310; page_cross=1.
  - Repeat with index=0x05: no FIX, ea=0x12F5.
- Mode 4, b=0xFE, index=0x01 -> PTR reads 0x00FF then 0x0000; with mem=34,12, ea=0x1234.
- Mode 6, pointer bytes FF,30 -> PTR_LO address 0x30FF, PTR_HI address 0x3000; 4 busy cycles.
- Mode 5, force_fix=1, no carry -> FIX present, page_cross=0, busy for 4 cycles. A start pulsed during busy is ignored and yields exactly one done.
- Mode 2 with rst=0 asserted in OP_HI -> next cycle IDLE, ea=0, no done. A fresh start then completes normally.
